// File: rtl/result_drain.sv
// Drains ARRAYWIDTH rows from the systolic array output buffer. Each lane gets
// ReLU, an arithmetic shift and saturation, and each row is written to result memory.
module result_drain #(
  parameter int ARRAYWIDTH = 4,
  parameter int IN_W       = 32,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        relu_en,
  input  logic [$clog2(IN_W)-1:0]     shift_amt,
  input  logic [ARRAYWIDTH*IN_W-1:0]  out_res,
  output logic                        out_en,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [ARRAYWIDTH*OUT_W-1:0] wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int SH_W  = $clog2(IN_W);
  localparam int CNT_W = $clog2(ARRAYWIDTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 2);
  localparam int ROW_W = ARRAYWIDTH * OUT_W;

  localparam logic signed [IN_W-1:0] SAT_MAX  = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [CNT_W-1:0]       LAST_ROW = CNT_W'(ARRAYWIDTH - 1);
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  function automatic logic signed [IN_W-1:0] relu_shift(
    input logic signed [IN_W-1:0] x,
    input logic                   relu,
    input logic [SH_W-1:0]        sh
  );
    logic signed [IN_W-1:0] v;
    v = (relu && x[IN_W-1]) ? '0 : x;
    return v >>> sh;
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] y);
    if (y > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (y < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return y[OUT_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               relu_q, relu_d;
  logic [SH_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               pipe_vld_q, pipe_vld_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FC_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [ROW_W-1:0]   pipe_row_q;
  logic [ROW_W-1:0]   fifo_q [FIFO_DEPTH];

  logic               not_empty;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ;
  logic [ROW_W-1:0]   proc_row;

  always_comb begin
    proc_row = '0;
    for (int i = 0; i < ARRAYWIDTH; i++) begin
      proc_row[i*OUT_W +: OUT_W] =
        saturate(relu_shift($signed(out_res[i*IN_W +: IN_W]), relu_q, shift_q));
    end
  end

  // Issue only when the row cannot overrun the FIFO; counting this cycle's
  // pop makes out_en depend combinationally on wr_ready, keeping one row per cycle.
  assign not_empty = (fifo_cnt_q != '0);
  assign pop       = not_empty & wr_ready;
  assign push      = pipe_vld_q;
  assign occ       = OCC_W'(fifo_cnt_q) + OCC_W'(pipe_vld_q);
  assign issue     = (state_q == S_DRAIN) && ((occ - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRAIN;
      S_DRAIN: if (issue && (iss_cnt_q == LAST_ROW)) state_d = S_FLUSH;
      S_FLUSH: if (pop && (wr_cnt_q == LAST_ROW)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_en   = issue;
    busy     = (state_q == S_DRAIN) || (state_q == S_FLUSH);
    done     = (state_q == S_DONE);
    wr_valid = not_empty;
    wr_data  = not_empty ? fifo_q[rd_ptr_q] : '0;
    wr_addr  = not_empty ? (base_q + ADDR_W'(wr_cnt_q) * ADDR_W'(ROW_STRIDE)) : '0;
  end

  always_comb begin
    base_d     = base_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    iss_cnt_d  = iss_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pipe_vld_d = issue;
    if ((state_q == S_IDLE) && start) begin
      base_d    = base_addr;
      relu_d    = relu_en;
      shift_d   = shift_amt;
      iss_cnt_d = '0;
      wr_cnt_d  = '0;
    end
    if (issue) iss_cnt_d = iss_cnt_q + 1'b1;
    if (pop) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    fifo_cnt_d = fifo_cnt_q + FC_W'(push) - FC_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      iss_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      pipe_vld_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      base_q     <= base_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      iss_cnt_q  <= iss_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Row payloads carry no reset; the valid bits and FIFO count qualify them.
  always_ff @(posedge clk) begin
    if (issue) pipe_row_q <= proc_row;
    if (push)  fifo_q[wr_ptr_q] <= pipe_row_q;
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: an output-buffer model feeds rows, and every
// accepted write is captured and compared with hand-computed rows and addresses.
module tb_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  base_addr;
  logic         relu_en;
  logic [4:0]   shift_amt;
  logic [127:0] out_res;
  logic         out_en;
  logic         wr_valid;
  logic         wr_ready;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         busy;
  logic         done;

  logic [127:0] ob_rows [0:63];
  logic [5:0]   ob_idx;

  int total = 0;
  int bad   = 0;

  logic [15:0] cap_addr [0:15];
  logic [31:0] cap_data [0:15];
  int cap_n, oe_n, oe_first, oe_last, last_acc, done_n, done_at, stall_diff, oe_at10, leak;
  logic        busy1, snap_v;
  logic [15:0] snap_a;
  logic [31:0] snap_d;

  always #5 clk = ~clk;

  result_drain #(
    .ARRAYWIDTH(4), .IN_W(32), .OUT_W(8), .ADDR_W(16), .ROW_STRIDE(1), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .relu_en(relu_en),
    .shift_amt(shift_amt), .out_res(out_res), .out_en(out_en), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)         ob_idx <= '0;
    else if (out_en) ob_idx <= ob_idx + 6'd1;
  end
  assign out_res = ob_rows[ob_idx];

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic load_rows(input logic [127:0] r0, input logic [127:0] r1,
                           input logic [127:0] r2, input logic [127:0] r3);
    ob_rows[ob_idx]         = r0;
    ob_rows[ob_idx + 6'd1]  = r1;
    ob_rows[ob_idx + 6'd2]  = r2;
    ob_rows[ob_idx + 6'd3]  = r3;
  endtask

  // mode 0: ready always; 1: ready low for cycles 0..10; 2: ready alternating;
  // 3: ready always with extra start pulses while busy and in the done cycle
  task automatic job(input logic [15:0] b, input logic r, input logic [4:0] s, input int mode);
    cap_n = 0; oe_n = 0; oe_first = -1; oe_last = -1; last_acc = -1;
    done_n = 0; done_at = -1; stall_diff = 0; oe_at10 = 0; busy1 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      start = (k == 0) || (mode == 3 && (k == 2 || k == 7));
      if (k == 0) begin
        base_addr = b; relu_en = r; shift_amt = s;
      end else begin
        base_addr = 16'h5A5A; relu_en = ~r; shift_amt = 5'd7;
      end
      case (mode)
        1:       wr_ready = (k > 10);
        2:       wr_ready = ((k % 2) == 1);
        default: wr_ready = 1'b1;
      endcase
      #1;
      if (out_en) begin
        oe_n++;
        if (oe_first < 0) oe_first = k;
        oe_last = k;
      end
      if (wr_valid && wr_ready && cap_n < 16) begin
        cap_addr[cap_n] = wr_addr;
        cap_data[cap_n] = wr_data;
        cap_n++;
        last_acc = k;
      end
      if (done) begin
        done_n++;
        done_at = k;
      end
      if (k == 1) busy1 = busy;
      if (mode == 1 && k == 3) begin
        snap_a = wr_addr; snap_d = wr_data; snap_v = wr_valid;
      end
      if (mode == 1 && k > 3 && k <= 10 &&
          (wr_addr !== snap_a || wr_data !== snap_d || wr_valid !== 1'b1))
        stall_diff++;
      if (k == 10) oe_at10 = oe_n;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_rows(input string tag, input logic [15:0] b,
                            input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [0:3];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk($sformatf("%s_writes", tag), cap_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), cap_addr[i], b + 16'(i));
      chk($sformatf("%s_data%0d", tag, i), cap_data[i], e[i]);
    end
    chk($sformatf("%s_done_count", tag), done_n, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_en"},   out_en,   1'b0);
    chk({tag, "_wr_valid"}, wr_valid, 1'b0);
    chk({tag, "_wr_addr"},  wr_addr,  16'h0);
    chk({tag, "_wr_data"},  wr_data,  32'h0);
    chk({tag, "_busy"},     busy,     1'b0);
    chk({tag, "_done"},     done,     1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; relu_en = 1'b0; shift_amt = '0; wr_ready = 1'b0;
    for (int i = 0; i < 64; i++) ob_rows[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // plain pass-through with saturation, full throughput
    load_rows(pk(100, 1, -200, 0), pk(-5, 2, 127, -128), pk(300, 3, 128, -129), pk(7, 4, -1, 5));
    job(16'h0100, 1'b0, 5'd0, 0);
    chk("t1_out_en_count", oe_n, 4);
    chk("t1_out_en_first", oe_first, 1);
    chk("t1_out_en_last", oe_last, 4);
    chk("t1_busy", busy1, 1'b1);
    chk("t1_done_after_accept", done_at, last_acc + 1);
    chk("t1_done_cycle", done_at, 7);
    check_rows("t1", 16'h0100, 32'h00800164, 32'h807F02FB, 32'h807F037F, 32'h05FF0407);

    // relu and shift by 2
    load_rows(pk(-40, 41, 1000, -1), pk(8, -8, 600, 3), pk(513, 4, 7, 512), pk(-1000, 20, 2, 508));
    job(16'h0200, 1'b1, 5'd2, 0);
    check_rows("t2", 16'h0200, 32'h007F0A00, 32'h007F0002, 32'h7F01017F, 32'h7F000500);

    // stall with wr_ready low, signed shift without relu
    load_rows(pk(-3, 255, -300, 10), pk(2, 4, 6, 8), pk(-256, -257, 256, 254), pk(1, -1, 0, -2));
    job(16'h0300, 1'b0, 5'd1, 1);
    chk("t3_out_en_during_stall", oe_at10, 2);
    chk("t3_stall_stable", stall_diff, 0);
    chk("t3_stall_valid", snap_v, 1'b1);
    chk("t3_stall_addr", snap_a, 16'h0300);
    chk("t3_stall_data", snap_d, 32'h05807FFE);
    chk("t3_out_en_count", oe_n, 4);
    check_rows("t3", 16'h0300, 32'h05807FFE, 32'h04030201, 32'h7F7F8080, 32'hFF00FF00);

    // alternating ready
    load_rows(pk(100, 1, -200, 0), pk(-5, 2, 127, -128), pk(300, 3, 128, -129), pk(7, 4, -1, 5));
    job(16'h0400, 1'b0, 5'd0, 2);
    chk("t4_out_en_count", oe_n, 4);
    check_rows("t4", 16'h0400, 32'h00800164, 32'h807F02FB, 32'h807F037F, 32'h05FF0407);

    // start pulses while busy and in the done cycle are ignored
    load_rows(pk(-40, 41, 1000, -1), pk(8, -8, 600, 3), pk(513, 4, 7, 512), pk(-1000, 20, 2, 508));
    job(16'h0500, 1'b1, 5'd2, 3);
    chk("t5_out_en_count", oe_n, 4);
    chk("t5_idle_after", busy, 1'b0);
    check_rows("t5", 16'h0500, 32'h007F0A00, 32'h007F0002, 32'h7F01017F, 32'h7F000500);

    // reset in the middle of DRAIN
    load_rows(pk(100, 1, -200, 0), pk(-5, 2, 127, -128), pk(300, 3, 128, -129), pk(7, 4, -1, 5));
    base_addr = 16'h0600; relu_en = 1'b0; shift_amt = 5'd0; wr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("abort_now");
    @(negedge clk);
    #1;
    check_idle_outputs("abort_next");
    rst = 1'b0;
    leak = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_en || wr_valid || busy || done) leak++;
    end
    chk("abort_quiet", leak, 0);

    load_rows(pk(100, 1, -200, 0), pk(-5, 2, 127, -128), pk(300, 3, 128, -129), pk(7, 4, -1, 5));
    job(16'h0700, 1'b0, 5'd0, 0);
    chk("t5b_out_en_count", oe_n, 4);
    check_rows("t5b", 16'h0700, 32'h00800164, 32'h807F02FB, 32'h807F037F, 32'h05FF0407);

    // address wrap
    load_rows(pk(-40, 41, 1000, -1), pk(8, -8, 600, 3), pk(513, 4, 7, 512), pk(-1000, 20, 2, 508));
    job(16'hFFFE, 1'b1, 5'd2, 0);
    chk("t6_addr0", cap_addr[0], 16'hFFFE);
    chk("t6_addr1", cap_addr[1], 16'hFFFF);
    chk("t6_addr2", cap_addr[2], 16'h0000);
    chk("t6_addr3", cap_addr[3], 16'h0001);
    chk("t6_data0", cap_data[0], 32'h007F0A00);
    chk("t6_data3", cap_data[3], 32'h7F000500);
    chk("t6_writes", cap_n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
